// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the non-restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Default operand width of the divider.
  localparam int DIV_WIDTH = 32;

  // Iteration counter width at the default operand width.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // Iteration counter width for an arbitrary operand width (never below 1).
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_addsub_stage.sv
`default_nettype none
// ============================================================================
// Module      : div_addsub_stage
// Description : Combinational (WIDTH+1)-bit add/subtract of the zero-extended
//               divisor magnitude to the partial remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module div_addsub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] m,
  input  logic             subtract,
  output logic [WIDTH:0]   result
);

  logic [WIDTH:0] m_ext;

  assign m_ext = {1'b0, m};

  // Subtract when the caller requests it, otherwise add.
  always_comb begin
    result = subtract ? (acc - m_ext) : (acc + m_ext);
  end

endmodule
`default_nettype wire

// File: rtl/non_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : non_restoring_divider
// Description : Sequential signed/unsigned divider, one non-restoring
//               add-or-subtract step per clock, with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module non_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;      // signed partial remainder A
  logic [WIDTH-1:0] q_reg;    // dividend magnitude shifting into quotient Q
  logic [WIDTH-1:0] m_reg;    // divisor magnitude M
  logic             neg_q;    // quotient must be negated at the end
  logic             neg_r;    // remainder must be negated at the end

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   shifted_acc;
  logic [WIDTH:0]   stage_in;
  logic             stage_sub;
  logic [WIDTH:0]   stage_out;
  logic [WIDTH:0]   fixed_acc;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // Operand magnitudes; only negative values in signed mode are negated.
  always_comb begin
    dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // Share one adder: RUN steps use the shifted A, FIX uses A for the correction add.
  always_comb begin
    shifted_acc = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
    if (state == ST_FIX) begin
      stage_in  = acc;
      stage_sub = 1'b0;
    end else begin
      stage_in  = shifted_acc;
      stage_sub = ~acc[WIDTH];   // operation chosen by the sign of A before the shift
    end
  end

  div_addsub_stage #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .acc      (stage_in),
    .m        (m_reg),
    .subtract (stage_sub),
    .result   (stage_out)
  );

  // Final correction and sign restoration of quotient and remainder.
  always_comb begin
    fixed_acc = acc[WIDTH] ? stage_out : acc;
    rem_mag   = fixed_acc[WIDTH-1:0];
    q_final   = neg_q ? -q_reg : q_reg;
    r_final   = neg_r ? -rem_mag : rem_mag;
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              // Divide by zero finishes immediately without ever raising busy.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              acc   <= '0;
              q_reg <= dividend_mag;
              m_reg <= divisor_mag;
              neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r <= is_signed & dividend[WIDTH-1];
              cnt   <= CNT_W'(WIDTH - 1);
              busy  <= 1'b1;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc   <= stage_out;
          q_reg <= {q_reg[WIDTH-2:0], ~stage_out[WIDTH]};
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_FIX: begin
          acc         <= fixed_acc;
          quotient    <= q_final;
          remainder   <= r_final;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_non_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_non_restoring_divider
// Description : Self-checking bench for non_restoring_divider (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_non_restoring_divider;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  non_restoring_divider #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference: plain integer division semantics.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = rr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one division from IDLE, wait for done (bounded), then step into IDLE.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int bcnt, output logic bdone,
                        output logic [31:0] q, output logic [31:0] r, output logic dz);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc   = 1;
    bcnt  = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clock); #1;
      cyc++;
    end
    bdone = busy;
    q     = quotient;
    r     = remainder;
    dz    = div_by_zero;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quotient got=%h want=0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder got=%h want=0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    clear = 1'b0;
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  task automatic test_directed();
    vec_t v[6];
    int cyc, bcnt, exp_cyc, exp_bcnt;
    logic bdone, dz;
    logic [31:0] q, r;
    v[0] = '{1'b1, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0};
    v[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0};
    v[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0};
    v[3] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        1'b0};
    v[4] = '{1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF,  32'h12345678, 1'b1};
    v[5] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        1'b0};
    for (int i = 0; i < 6; i++) begin
      do_div(v[i].s, v[i].a, v[i].b, cyc, bcnt, bdone, q, r, dz);
      exp_cyc  = v[i].dz ? 1 : 34;
      exp_bcnt = v[i].dz ? 0 : 33;
      n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, cyc, exp_cyc); end
      n_checks++; if (bcnt !== exp_bcnt) begin n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, bcnt, exp_bcnt); end
      n_checks++; if (bdone !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done got=%b want=0", i, bdone); end
      n_checks++; if (q !== v[i].q) begin n_fail++; $display("FAIL dir%0d_quotient got=%h want=%h", i, q, v[i].q); end
      n_checks++; if (r !== v[i].r) begin n_fail++; $display("FAIL dir%0d_remainder got=%h want=%h", i, r, v[i].r); end
      n_checks++; if (dz !== v[i].dz) begin n_fail++; $display("FAIL dir%0d_dbz got=%b want=%b", i, dz, v[i].dz); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got=%b want=0", i, done); end
      n_checks++; if (quotient !== v[i].q) begin n_fail++; $display("FAIL dir%0d_quotient_held got=%h want=%h", i, quotient, v[i].q); end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    is_signed = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 10) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
    end
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL ignore_latency got=%0d want=34", cyc); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL ignore_quotient got=%h want=%h", quotient, 32'd14); end
    n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL ignore_remainder got=%h want=%h", remainder, 32'd2); end
    @(posedge clock); #1;
  endtask

  task automatic test_clear_mid_run();
    int cyc, bcnt;
    logic bdone, dz;
    logic [31:0] q, r;
    is_signed = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc   = 1;
    while (cyc < 15) begin
      @(posedge clock); #1;
      cyc++;
    end
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clear_done got=%b want=0", done); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL clear_quotient got=%h want=0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL clear_remainder got=%h want=0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL clear_dbz got=%b want=0", div_by_zero); end
    do_div(1'b1, 32'd9, 32'd2, cyc, bcnt, bdone, q, r, dz);
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL post_clear_latency got=%0d want=34", cyc); end
    n_checks++; if (q !== 32'd4) begin n_fail++; $display("FAIL post_clear_quotient got=%h want=%h", q, 32'd4); end
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL post_clear_remainder got=%h want=%h", r, 32'd1); end
  endtask

  // Consecutive operations with start raised in the first IDLE cycle after DONE.
  task automatic test_back_to_back();
    int cyc, bcnt;
    logic bdone, dz, s;
    logic [31:0] a, b, q, r, eq, er;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: a = 32'h80000000;
        1: a = 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: b = (i % 7 == 3) ? 32'd0 : 32'hFFFFFFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(s, a, b, eq, er);
      do_div(s, a, b, cyc, bcnt, bdone, q, r, dz);
      n_checks++; if (cyc !== ((b == 32'd0) ? 1 : 34)) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d a=%h b=%h", i, cyc, a, b); end
      n_checks++; if (q !== eq) begin n_fail++; $display("FAIL rnd%0d_quotient s=%b a=%h b=%h got=%h want=%h", i, s, a, b, q, eq); end
      n_checks++; if (r !== er) begin n_fail++; $display("FAIL rnd%0d_remainder s=%b a=%h b=%h got=%h want=%h", i, s, a, b, r, er); end
      n_checks++; if (dz !== (b == 32'd0)) begin n_fail++; $display("FAIL rnd%0d_dbz got=%b want=%b", i, dz, (b == 32'd0)); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_clear_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/non_restoring_divider.md
# non_restoring_divider

Sequential signed/unsigned integer divider built on the team's add/subtract datapath. It runs one non-restoring add-or-subtract step per clock, which is the inverse of the lookahead multiply/add path. It sits beside the ALU and writes quotient to LO and remainder to HI for the `div` instruction. A start/busy/done handshake lets the control unit stall until the result is valid.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `clear`  in  1: synchronous, active-high reset.
- `start`  in  1: request a division; sampled only in IDLE.
- `is_signed`  in  1: 1 = two's-complement division, 0 = unsigned; captured with `start`.
- `dividend`  in  WIDTH: captured with `start`.
- `divisor`  in  WIDTH: captured with `start`.
- `busy`  out  1: high from the cycle after acceptance until DONE.
- `done`  out  1: one-cycle pulse; results are valid this cycle.
- `quotient`  out  WIDTH: result, held until the next accepted `start`.
- `remainder`  out  WIDTH: result, held until the next accepted `start`.
- `div_by_zero`  out  1: set with `done` when the divisor was 0; held like the results.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE + `start` + divisor≠0:
  - Latch the operand magnitudes. When `is_signed` is set, negate negative operands.
  - Latch the sign flags. Set A=0, Q=|dividend|, M=|divisor|, count=WIDTH−1. Go to RUN.
- IDLE + `start` + divisor=0: go to DONE. Quotient = all ones, remainder = dividend unchanged, `div_by_zero`=1.
- RUN, one step per cycle (A is WIDTH+1 bits, signed):
  - Shift {A,Q} left by 1.
  - If A≥0 before the shift, A=A−M; otherwise A=A+M.
  - Q[0] = ~A[WIDTH] after the add/subtract.
  - At count=0 go to FIX; otherwise decrement count.
- FIX:
  - If A<0, add M back to A.
  - Negate Q when the operand signs differ (signed mode only).
  - Negate A when the dividend was negative (signed mode only).
  - Register the results to the outputs. Go to DONE.
- DONE: `done`=1 and `busy`=0, then go to IDLE.
- Signed semantics: the quotient truncates toward zero and the remainder takes the sign of the dividend.
- Signed MIN/−1 wraps: quotient = MIN, remainder = 0. No overflow flag.
- `start` while not IDLE is ignored; operands are not re-captured.
- `clear` at any cycle, including mid-RUN, has priority over everything else:
  - State returns to IDLE.
  - `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder` = 0.
  - An operation in flight is discarded.

## Timing
- Reset values: all outputs 0; state IDLE.
- Cycle 0: `start` is sampled in IDLE.
- Cycles 1..WIDTH: RUN, `busy`=1 (32 cycles at the default width).
- Cycle WIDTH+1: FIX, `busy`=1.
- Cycle WIDTH+2: DONE, `done`=1 and outputs valid. This is 34 cycles at WIDTH=32.
- Divide by zero: `done` at cycle 1; `busy` is never asserted.
- A new `start` is accepted in the cycle after DONE, which gives 35-cycle back-to-back throughput.
- Outputs change only on entering DONE or on `clear`.

## Structure
- Shared package `div_pkg` holds:
  - the state enum (IDLE/RUN/FIX/DONE);
  - the default `DIV_WIDTH`=32;
  - the count width, $clog2(WIDTH).
- Sub-module `div_addsub_stage`: combinational (WIDTH+1)-bit add/subtract selected by the sign of A, instantiated once in RUN and reused in FIX for the correction add.
- Everything else (control FSM, counter, operand/sign registers, output registers) lives in the top module.

## Test plan
- Signed 100 ÷ 7, `start` at cycle 0 → `done` at cycle 34; quotient=14, remainder=2, `div_by_zero`=0.
- Signed −100 ÷ 7 → quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2).
- Signed 0x80000000 ÷ 0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF ÷ 1 → quotient=0xFFFFFFFF, remainder=0.
- Divisor 0, dividend 0x12345678 → `done` at cycle 1; quotient=0xFFFFFFFF, remainder=0x12345678, `div_by_zero`=1, `busy` never high.
- `start` with 50 ÷ 5 during cycle 10 of a running 100 ÷ 7 → ignored; the result is still 14 r 2 at cycle 34.
- `clear` at cycle 15 of a RUN → next cycle IDLE with all outputs 0. A fresh 9 ÷ 2 then completes in 34 cycles with quotient=4, remainder=1.
